// File: rtl/vrased_rst_seq_if.sv
// Bundle of the violation/reset/status signals between the VRASED monitors,
// the reset sequencer and the trusted status requester.
interface vrased_rst_seq_if #(
    parameter int NUM_SRC = 6,
    parameter int CNT_W   = 8
);
    logic [NUM_SRC-1:0] viol;
    logic [15:0]        pc;
    logic               clr_req;
    logic               clr_ack;
    logic               sys_rst;
    logic [NUM_SRC-1:0] cause;
    logic [CNT_W-1:0]   viol_cnt;
    logic               busy;

    modport master (
        output viol, pc, clr_req,
        input  clr_ack, sys_rst, cause, viol_cnt, busy
    );

    modport slave (
        input  viol, pc, clr_req,
        output clr_ack, sys_rst, cause, viol_cnt, busy
    );
endinterface

// File: rtl/vrased_rst_seq.sv
// Turns VRASED monitor violations into a stretched, registered core reset,
// records sticky cause bits and a saturating violation count.
module vrased_rst_seq #(
    parameter int          NUM_SRC       = 6,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          WAIT_MAX      = 64,
    parameter int          CNT_W         = 8,
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    vrased_rst_seq_if.slave  bus_io
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WAIT_W = $clog2(WAIT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_PC = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               sys_rst_q,  sys_rst_d;
    logic               busy_q,     busy_d;
    logic [NUM_SRC-1:0] cause_q,    cause_d;
    logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;
    logic               clr_ack_q,  clr_ack_d;
    logic               clr_lock_q, clr_lock_d;
    logic               clr_fire_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Next-state, status and handshake logic; clear is applied before the
    // capture so a coincident IDLE->HOLD entry leaves cause=viol, count=1.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wait_cnt_d = wait_cnt_q;

        clr_fire_s = bus_io.clr_req & ~clr_lock_q & ~clr_ack_q;
        clr_lock_d = bus_io.clr_req & (clr_lock_q | clr_fire_s);
        clr_ack_d  = clr_fire_s;

        if (clr_fire_s) begin
            cause_d    = {NUM_SRC{1'b0}};
            viol_cnt_d = {CNT_W{1'b0}};
        end else begin
            cause_d    = cause_q;
            viol_cnt_d = viol_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (|bus_io.viol) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                    cause_d    = cause_d | bus_io.viol;
                    viol_cnt_d = sat_inc(viol_cnt_d);
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == {HOLD_W{1'b0}}) begin
                    state_d    = ST_WAIT_PC;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1'b1);
                end
            end
            ST_WAIT_PC: begin
                // Monitors may still flag a stale pc here, so viol is ignored.
                if (bus_io.pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                    viol_cnt_d = sat_inc(viol_cnt_d);
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sys_rst_d = (state_d == ST_HOLD);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            wait_cnt_q <= {WAIT_W{1'b0}};
            sys_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            cause_q    <= {NUM_SRC{1'b0}};
            viol_cnt_q <= {CNT_W{1'b0}};
            clr_ack_q  <= 1'b0;
            clr_lock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sys_rst_q  <= sys_rst_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
            viol_cnt_q <= viol_cnt_d;
            clr_ack_q  <= clr_ack_d;
            clr_lock_q <= clr_lock_d;
        end
    end

    assign bus_io.sys_rst  = sys_rst_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.cause    = cause_q;
    assign bus_io.viol_cnt = viol_cnt_q;
    assign bus_io.clr_ack  = clr_ack_q;

endmodule

// File: tb/tb_vrased_rst_seq.sv
// Scoreboard bench: a cycle-level reference model predicts every output, a
// monitor compares two DUTs (8-bit and 2-bit counters) sharing one stimulus.
module tb_vrased_rst_seq;

    localparam int          NS = 6;
    localparam int          HC = 8;
    localparam int          WM = 64;
    localparam logic [15:0] RH = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vrased_rst_seq_if #(.NUM_SRC(NS), .CNT_W(8)) bus8 ();
    vrased_rst_seq_if #(.NUM_SRC(NS), .CNT_W(2)) bus2 ();

    assign bus2.viol    = bus8.viol;
    assign bus2.pc      = bus8.pc;
    assign bus2.clr_req = bus8.clr_req;

    vrased_rst_seq #(.NUM_SRC(NS), .HOLD_CYCLES(HC), .WAIT_MAX(WM), .CNT_W(8), .RESET_HANDLER(RH))
        u_dut8 (.clk_i(clk), .rst_i(rst), .bus_io(bus8.slave));
    vrased_rst_seq #(.NUM_SRC(NS), .HOLD_CYCLES(HC), .WAIT_MAX(WM), .CNT_W(2), .RESET_HANDLER(RH))
        u_dut2 (.clk_i(clk), .rst_i(rst), .bus_io(bus2.slave));

    typedef struct packed {
        logic          sys_rst;
        logic          busy;
        logic          ack;
        logic [NS-1:0] cause;
        logic [7:0]    cnt8;
        logic [1:0]    cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: reset remaining, waiting flag, wait age, sticky data.
    int          m_left, m_age, m_cnt8, m_cnt2;
    bit          m_wait, m_ack, m_block;
    logic [NS-1:0] m_cause;

    task automatic model_reset();
        m_left = 0; m_age = 0; m_cnt8 = 0; m_cnt2 = 0;
        m_wait = 1'b0; m_ack = 1'b0; m_block = 1'b0;
        m_cause = '0;
    endtask

    task automatic bump();
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    endtask

    task automatic step(input logic [NS-1:0] v, input logic [15:0] p, input logic c);
        exp_t e;
        bit   fire, nb;
        @(negedge clk);
        bus8.viol = v; bus8.pc = p; bus8.clr_req = c;
        fire = c && !m_block && !m_ack;
        nb   = c && (m_block || fire);
        if (fire) begin
            m_cause = '0; m_cnt8 = 0; m_cnt2 = 0;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_wait = 1'b1; m_age = 0;
            end
        end else if (m_wait) begin
            if (p == RH) begin
                m_wait = 1'b0;
            end else begin
                m_age++;
                if (m_age == WM) begin
                    m_wait = 1'b0; m_left = HC; bump();
                end
            end
        end else if (v != '0) begin
            m_cause = m_cause | v; m_left = HC; bump();
        end
        m_ack = fire; m_block = nb;
        e.sys_rst = (m_left > 0);
        e.busy    = (m_left > 0) || m_wait;
        e.ack     = m_ack;
        e.cause   = m_cause;
        e.cnt8    = 8'(m_cnt8);
        e.cnt2    = 2'(m_cnt2);
        sb.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus8.sys_rst, bus8.busy, bus8.clr_ack, bus8.cause, bus8.viol_cnt,
             bus2.sys_rst, bus2.busy, bus2.clr_ack, bus2.cause, bus2.viol_cnt} !== '0) begin
            errors++;
            $display("FAIL %s t=%0t got rst=%b/%b busy=%b/%b ack=%b/%b cause=%b/%b cnt=%0d/%0d, expected all zero",
                     name, $time, bus8.sys_rst, bus2.sys_rst, bus8.busy, bus2.busy, bus8.clr_ack, bus2.clr_ack,
                     bus8.cause, bus2.cause, bus8.viol_cnt, bus2.viol_cnt);
        end
    endtask

    // Monitor: pops one prediction per clock and compares both DUTs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({bus8.sys_rst, bus8.busy, bus8.clr_ack, bus8.cause, bus8.viol_cnt} !==
                    {e.sys_rst, e.busy, e.ack, e.cause, e.cnt8}) begin
                    errors++;
                    $display("FAIL dut8 t=%0t got rst=%b busy=%b ack=%b cause=%b cnt=%0d expected rst=%b busy=%b ack=%b cause=%b cnt=%0d",
                             $time, bus8.sys_rst, bus8.busy, bus8.clr_ack, bus8.cause, bus8.viol_cnt,
                             e.sys_rst, e.busy, e.ack, e.cause, e.cnt8);
                end
                checks++;
                if ({bus2.sys_rst, bus2.busy, bus2.clr_ack, bus2.cause, bus2.viol_cnt} !==
                    {e.sys_rst, e.busy, e.ack, e.cause, e.cnt2}) begin
                    errors++;
                    $display("FAIL dut2 t=%0t got rst=%b busy=%b ack=%b cause=%b cnt=%0d expected rst=%b busy=%b ack=%b cause=%b cnt=%0d",
                             $time, bus2.sys_rst, bus2.busy, bus2.clr_ack, bus2.cause, bus2.viol_cnt,
                             e.sys_rst, e.busy, e.ack, e.cause, e.cnt2);
                end
            end
        end
    end

    initial begin
        logic          clr_r;
        logic [NS-1:0] rv;
        logic [15:0]   rp;
        bus8.viol = '0; bus8.pc = 16'hE000; bus8.clr_req = 1'b0;
        model_reset();
        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Single violation, hold, then release with ignored viol in WAIT_PC.
        step(6'b000010, 16'hE000, 1'b0);
        repeat (HC) step(6'b000000, 16'hE000, 1'b0);
        repeat (10) step(NS'($urandom), 16'hE000, 1'b0);
        step(6'b000000, 16'h0000, 1'b0);
        step(6'b000000, 16'hE000, 1'b0);

        // Timeout path: pc never reaches the handler.
        step(6'b010000, 16'hE000, 1'b0);
        repeat (HC + WM + HC + 4) step(6'b000000, 16'hE000, 1'b0);
        step(6'b000000, 16'h0000, 1'b0);
        step(6'b000000, 16'h0000, 1'b0);

        // Clear handshake with requester holding clr_req for 3 cycles.
        repeat (3) step(6'b000000, 16'h0000, 1'b1);
        step(6'b000000, 16'h0000, 1'b0);

        // Simultaneous sources, then a later source ORs in.
        step(6'b100001, 16'hE000, 1'b0);
        repeat (HC) step(6'b000000, 16'hE000, 1'b0);
        step(6'b000000, 16'h0000, 1'b0);
        step(6'b000100, 16'h0000, 1'b0);
        repeat (HC + 2) step(6'b000000, 16'h0000, 1'b0);

        // Clear coincident with IDLE->HOLD: capture wins.
        step(6'b000001, 16'h0000, 1'b1);
        step(6'b000000, 16'h0000, 1'b0);
        repeat (HC + 2) step(6'b000000, 16'h0000, 1'b0);

        // Randomized traffic.
        clr_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rv = ($urandom_range(0, 12) == 0) ? NS'($urandom) : '0;
            rp = ($urandom_range(0, 9) == 0) ? 16'h0000 : (16'hE000 | 16'($urandom_range(1, 255)));
            if ($urandom_range(0, 5) == 0) clr_r = ~clr_r;
            step(rv, rp, clr_r);
        end
        step(6'b000000, 16'h0000, 1'b0);

        // Continuous violation: loops IDLE->HOLD->WAIT_PC->IDLE, saturating cnt2.
        repeat (60) step(6'b001000, 16'h0000, 1'b0);
        repeat (HC + 4) step(6'b000000, 16'h0000, 1'b0);

        // Async reset in the middle of HOLD.
        step(6'b000001, 16'hE000, 1'b0);
        repeat (3) step(6'b000000, 16'hE000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset_mid_hold");
        @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(6'b000100, 16'hE000, 1'b0);
        repeat (4) step(6'b000000, 16'hE000, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
